// File: rtl/mem_port_arbiter.sv
// Shares one single-ported data memory between instruction fetch (IF) and load/store (D).
// Arbitrates, runs the req/ack/valid handshake, registers read data and flags timeouts.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int FAIR_N  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_mask,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        err_o,
    output logic        busy_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int              FW       = ($clog2(FAIR_N + 1) < 1) ? 1 : $clog2(FAIR_N + 1);
    localparam logic [FW-1:0]   FAIR_MAX = FW'(FAIR_N);
    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          owner_d;
    logic [FW-1:0] fair_cnt;
    logic [7:0]    tmo_cnt;
    logic          pick_d, pick_if, finish, fin_err;

    always_comb begin
        pick_d  = 1'b0;
        pick_if = 1'b0;
        finish  = 1'b0;
        fin_err = 1'b0;
        case (state)
            IDLE: begin
                // D wins unless IF has already been passed over FAIR_N times in a row
                pick_d  = d_req && !(if_req && fair_cnt == FAIR_MAX);
                pick_if = if_req && !pick_d;
            end
            REQ:  finish = mem_ack && mem_valid;
            WAIT: begin
                finish  = mem_valid || (tmo_cnt == TMO_LAST);
                fin_err = !mem_valid && (tmo_cnt == TMO_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            fair_cnt  <= '0;
            tmo_cnt   <= '0;
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_mask  <= '0;
            mem_wdata <= '0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err_o    <= 1'b0;

            if (pick_d || pick_if) begin
                state     <= REQ;
                busy_o    <= 1'b1;
                owner_d   <= pick_d;
                d_gnt     <= pick_d;
                if_gnt    <= pick_if;
                mem_req   <= 1'b1;
                mem_we    <= pick_d && d_we;
                mem_addr  <= pick_d ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
                mem_mask  <= (pick_d && d_we) ? d_mask : 4'hF;
                mem_wdata <= pick_d ? d_wdata : '0;
                if (pick_d && if_req)
                    fair_cnt <= (fair_cnt == '1) ? fair_cnt : fair_cnt + 1'b1;
                else
                    fair_cnt <= '0;
            end

            if (state == REQ && mem_ack && !mem_valid) begin
                state   <= WAIT;
                mem_req <= 1'b0;
                tmo_cnt <= '0;
            end

            if (state == WAIT && !finish)
                tmo_cnt <= tmo_cnt + 8'd1;

            if (finish) begin
                state     <= IDLE;
                busy_o    <= 1'b0;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_mask  <= '0;
                mem_wdata <= '0;
                err_o     <= fin_err;
                // stores and timeouts return a zero word
                if (owner_d) begin
                    d_valid <= 1'b1;
                    d_rdata <= (fin_err || mem_we) ? '0 : mem_rdata;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= fin_err ? '0 : mem_rdata;
                end
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported data memory between the instruction-fetch requester (IF) and the load/store requester (D, after the byte-lane wrapper has produced mask and lane-aligned data).
- Arbitrates between them, sequences each transfer through a req/ack/valid handshake, and returns registered read data.
- Detects memory timeouts.
- Sits between the pipeline's IF/MEM stages and the memory bus.

Parameters:
TIMEOUT, 15, max cycles in WAIT without mem_valid before error completion (1..255)
FAIR_N, 2, consecutive D grants allowed while IF is pending before IF is forced

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  IF request, held until if_gnt
if_addr  input  32  IF byte address
if_gnt  output  1  one-cycle pulse: IF request captured
if_valid  output  1  one-cycle pulse: IF response
if_rdata  output  32  IF read data, valid with if_valid
d_req  input  1  data request, held until d_gnt
d_we  input  1  1=store, 0=load
d_addr  input  32  data byte address
d_mask  input  4  byte-lane write enables
d_wdata  input  32  lane-aligned store data
d_gnt  output  1  one-cycle pulse: D request captured
d_valid  output  1  one-cycle pulse: D response (load data or store done)
d_rdata  output  32  raw memory word, valid with d_valid
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_mask  output  4  lane mask; 4'b1111 for IF and D loads
mem_wdata  output  32  write data
mem_ack  input  1  memory accepted request
mem_valid  input  1  memory completed (read data or write done)
mem_rdata  input  32  memory read data
err_o  output  1  one-cycle pulse with the valid of a timed-out transfer
busy_o  output  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, fairness counter 0, timeout counter 0. Reset asserted mid-transfer aborts immediately (mem_req drops asynchronously). The pending response is discarded and no valid is issued.
- All outputs are registered. mem_* outputs hold the captured request fields for the whole transfer and read 0 in IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE, at a clock edge:
  - If d_req is sampled and not (if_req and fair_cnt==FAIR_N): capture D, go to REQ, pulse d_gnt in the next cycle. If if_req was also high, fair_cnt++ (saturating); otherwise fair_cnt=0.
  - Else if if_req: capture IF, go to REQ, pulse if_gnt, fair_cnt=0.
  - Else stay in IDLE.
- Requesters drop req in the gnt cycle. A req still high when the arbiter returns to IDLE is treated as a new request.
- REQ: mem_req=1.
  - mem_ack and mem_valid both sampled: complete (see below), go to IDLE.
  - mem_ack only: go to WAIT, tmo_cnt=0.
  - Otherwise hold. REQ has no timeout.
- WAIT: mem_req=0.
  - mem_valid: complete, go to IDLE.
  - Otherwise tmo_cnt++. On the edge where tmo_cnt==TIMEOUT-1 with no mem_valid: error-complete, go to IDLE.
- Complete: the owner's valid pulses for one cycle after the edge. rdata is registered from mem_rdata. For a store, d_rdata=0.
- Error-complete: the owner's valid and err_o pulse together, with rdata=0.
- mem_valid sampled in IDLE, or in REQ without mem_ack, is ignored.
- Minimum latency: req sampled at edge 0, same-cycle ack+valid at edge 1, valid visible in the cycle after edge 1 (2 cycles).
- The next request can be captured at the same edge that completes: no. The arbiter always spends at least one cycle in IDLE between transfers.
- if_valid and d_valid are never high together. Each gnt pulse is followed by exactly one valid.

Test Plan:
- IF only, if_addr=0x0000_0106, memory acks and returns 0xDEADBEEF in the same cycle → mem_addr=0x104, mem_mask=4'hF, if_gnt pulse, if_valid with if_rdata=0xDEADBEEF 2 cycles after req sampled.
- d_req store with d_mask=4'b0100, d_wdata=0x00AB0000, addr 0x202, ack at cycle 1, valid at cycle 4 → mem_we=1, mem_addr=0x200, mem_mask=4'b0100, d_valid=1, d_rdata=0, err_o=0.
- if_req and d_req held continuously, FAIR_N=2, zero-wait memory → grant order D,D,I,D,D,I…; if_gnt never absent for more than 2 consecutive transfers.
- Acked load, mem_valid never asserted, TIMEOUT=15 → d_valid and err_o pulse together after 15 WAIT cycles, d_rdata=0, next request accepted.
- rst asserted in WAIT, then late mem_valid after release → all outputs 0 immediately, no valid pulse, late mem_valid ignored, busy_o=0.
- Spurious mem_valid in IDLE with rdata 0x1234 → no valid pulse, rdata outputs unchanged.
